// File: rtl/nibble_serial_adder_if.sv
// Client-side bundle for nibble_serial_adder: start/busy/done handshake, operands and result.
// Optional NIBBLE_SERIAL_ADD_OVF_EN adds the o_overflow result bit.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
) ();
  localparam int W = 4 * NIBBLES;

  logic         i_start;
  logic [W-1:0] i_op1;
  logic [W-1:0] i_op2;
  logic         i_carry_in;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_sum;
  logic         o_carry_out;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
  logic         o_overflow;
`endif

  // Client side: issues requests and observes results.
  modport master (
    output i_start, i_op1, i_op2, i_carry_in,
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    input  o_overflow,
`endif
    input  o_busy, o_done, o_sum, o_carry_out
  );

  // Adder side.
  modport slave (
    input  i_start, i_op1, i_op2, i_carry_in,
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    output o_overflow,
`endif
    output o_busy, o_done, o_sum, o_carry_out
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Serial W-bit adder (W = 4*NIBBLES, NIBBLES in 2..8) that pushes one nibble per cycle through a
// single four_bit_adder slice. Define NIBBLE_SERIAL_ADD_OVF_EN to add signed-overflow output.

module four_bit_adder (
  input  logic [3:0] i_op1,
  input  logic [3:0] i_op2,
  input  logic       i_carry_in,
  output logic [3:0] o_sum,
  output logic       o_carry_out
);
  logic c;

  always_comb begin
    c = i_carry_in;
    o_sum = '0;
    for (int i = 0; i < 4; i++) begin
      o_sum[i] = i_op1[i] ^ i_op2[i] ^ c;
      c = (i_op1[i] & i_op2[i]) | (c & (i_op1[i] ^ i_op2[i]));
    end
    o_carry_out = c;
  end
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  nibble_serial_adder_if.slave bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [3:0] slice_a;
  logic [3:0] slice_b;
  logic [3:0] slice_sum;
  logic       slice_cout;

  // Select the current nibble of each latched operand.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (cnt_q == CNT_W'(n)) begin
        slice_a = a_q[4*n +: 4];
        slice_b = b_q[4*n +: 4];
      end
    end
  end

  four_bit_adder u_slice (
    .i_op1      (slice_a),
    .i_op2      (slice_b),
    .i_carry_in (carry_q),
    .o_sum      (slice_sum),
    .o_carry_out(slice_cout)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          a_d     = bus.i_op1;
          b_d     = bus.i_op2;
          carry_d = bus.i_carry_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (cnt_q == CNT_W'(n)) sum_d[4*n +: 4] = slice_sum;
        end
        carry_d = slice_cout;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          cout_d  = slice_cout;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
          // Carry into the MSB is recovered from the MSB's own sum bit.
          ovf_d = (slice_a[3] ^ slice_b[3] ^ slice_sum[3]) ^ slice_cout;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: reset is synchronous and clears every register, operands included, so an aborted
  // operation leaves no stale state behind.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values of the others.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_sum       = sum_q;
  assign bus.o_carry_out = cout_q;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
  assign bus.o_overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NIBBLES=4): stimulus pushes expected results,
// a negedge monitor pops and compares on every o_done.
module tb_nibble_serial_adder;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with o_done high must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_done !== 1'b0 && !rst) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(bus.o_done), 64'd0);
        end else begin
          e = sb.pop_front();
          check("sum", 64'(bus.o_sum), 64'(e.sum));
          check("carry_out", 64'(bus.o_carry_out), 64'(e.cout));
          check("done_latency", 64'(cyc - e.acc_cyc), 64'(NIBBLES));
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
          check("overflow", 64'(bus.o_overflow), 64'(e.ovf));
`endif
        end
      end
    end
  end

  // One operation; glitch > 0 pulses i_start with a different operand in that busy cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                        input int glitch);
    exp_t e;
    int   k;
    int   busy_cycles;
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_op1      = a;
    bus.i_op2      = b;
    bus.i_carry_in = cin;
    @(posedge clk);
    #1;
    e.sum = exp_sum;
    e.cout = exp_cout;
    e.ovf = exp_ovf;
    e.acc_cyc = cyc;
    sb.push_back(e);
    k = 1;
    busy_cycles = 0;
    @(negedge clk);
    while (bus.o_busy === 1'b1 && k < 40) begin
      busy_cycles++;
      if (k == glitch) begin
        bus.i_start = 1'b1;
        bus.i_op1   = 16'hAAAA;
      end else begin
        bus.i_start    = 1'b0;
        bus.i_op1      = ~a;
        bus.i_op2      = ~b;
        bus.i_carry_in = ~cin;
      end
      @(negedge clk);
      k++;
    end
    bus.i_start = 1'b0;
    check("busy_cycles", 64'(busy_cycles), 64'(NIBBLES + 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
    check({tag, "_done"}, 64'(bus.o_done), 64'd0);
    check({tag, "_sum"}, 64'(bus.o_sum), 64'd0);
    check({tag, "_cout"}, 64'(bus.o_carry_out), 64'd0);
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, 64'(bus.o_overflow), 64'd0);
`endif
  endtask

  initial begin
    logic [W:0] full;
    logic [W-1:0] a, b;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_op1 = '0;
    bus.i_op2 = '0;
    bus.i_carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-computed results.
    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
    // Second start in busy cycle 2 must be ignored.
    run_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 2);

`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    check("ovf_7fff_hold", 64'(bus.o_overflow), 64'd1);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
    check("ovf_8000_hold", 64'(bus.o_overflow), 64'd1);
    run_op(16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    check("ovf_0001_hold", 64'(bus.o_overflow), 64'd0);
`endif

    // Held result after done.
    run_op(16'h0123, 16'h0456, 1'b1, 16'h057A, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("sum_hold", 64'(bus.o_sum), 64'h057A);

    // Abort by reset two cycles into an operation: no done, outputs cleared.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op1 = 16'h1234;
    bus.i_op2 = 16'h1111;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (NIBBLES + 3) @(negedge clk);
    run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

    // Reset and start on the same edge: reset wins.
    @(negedge clk);
    rst = 1'b1;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    check("rst_vs_start_busy", 64'(bus.o_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_start = 1'b0;
    repeat (NIBBLES + 3) @(negedge clk);

    // Nibble-0 sweep over all pairs and carry-in; upper nibbles zero.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int c = 0; c < 2; c++) begin
          a = W'(i);
          b = W'(j);
          full = {1'b0, a} + {1'b0, b} + (W + 1)'(c);
          run_op(a, b, 1'(c), full[W-1:0], full[W], 1'b0, 0);
        end
      end
    end

    repeat (4) @(negedge clk);
    check("pending_results", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
